cru_cpub_clken_ctrl: RTL and testbench
======================================

Name: cru_cpub_clken_ctrl

Overview:
Parametrised clock-enable and core-reset controller for the CPU subsystem clock/reset unit. It is the successor to the fixed 3-divider, 4-core CPU-block wrapper.
- Generates NUM_DIV divided clock enables from clk_cpub, each with its own divide ratio. Ratios can be updated glitch-free at runtime.
- Runs one WFI/WFE idle-gating FSM per core, with a programmable hysteresis threshold and interrupt wake-up.
- Sequences per-core soft-reset release.
- Sits between the CRU register block and the clock-gate cells / CPU reset inputs.

Parameters:
- NUM_CORE, 4, number of CPU cores (1..8).
- NUM_DIV, 3, number of divided enable channels (1..8); channel 0 = aclk, 1 = pclk, 2 = periphclk.
- DIV_W, 4, width of each divide field; field value v gives ratio v+1.
- IDLE_W, 8, width of the idle hysteresis counter.
- RST_DLY, 16, clk_cpub cycles ncorereset stays low after a reset request drops (>=1).

Ports:
- clk_cpub  in  1  CPU subsystem root clock.
- rst_cpub  in  1  synchronous reset, active-high.
- div_con  in  NUM_DIV*DIV_W  requested divide values; field i = bits [i*DIV_W +: DIV_W].
- div_upd  in  1  single-cycle request to apply div_con.
- div_busy  out  1  update pending.
- div_upd_done  out  1  one-cycle pulse: all channels now use the new ratios.
- clken_div  out  NUM_DIV  one-cycle-wide enables, one per channel.
- standbywfi  in  NUM_CORE  core in WFI.
- standbywfe  in  NUM_CORE  core in WFE.
- nIRQ  in  NUM_CORE  active-low IRQ to the core.
- nFIQ  in  NUM_CORE  active-low FIQ to the core.
- wfi_ckg_en  in  NUM_CORE  allow gating on WFI.
- wfe_ckg_en  in  NUM_CORE  allow gating on WFE.
- idle_thresh  in  IDLE_W  idle cycles required before gating.
- core_rst_req  in  NUM_CORE  level soft-reset request per core.
- core_clk_en  out  NUM_CORE  core clock-gate enable.
- ncorereset  out  NUM_CORE  active-low core reset.

Behaviour:
Reset (rst_cpub=1):
- Outputs: clken_div=0, core_clk_en=all 1, ncorereset=0, div_busy=0, div_upd_done=0.
- Each channel's active ratio div_act[i] loads div_con[i] every reset cycle.
- Channel counters cnt[i] clear to 0.
- Reset-delay counters load RST_DLY.

Divider channel i:
- clken_div[i] = (cnt[i]==0) && !rst_cpub.
- cnt[i] increments each cycle; when cnt[i]==div_act[i] it wraps to 0.
- div_act=0 gives clken_div high every cycle.
- The first enable occurs in the first cycle after reset deasserts.
- All channels start phase-aligned.

Divider update:
- div_upd with div_busy=0: capture div_con into a shadow register, set a pending bit per channel, and raise div_busy the next cycle.
- Each channel loads its shadow into div_act on the cycle its cnt wraps to 0. The enable pulse at that wrap is never lost or doubled.
- When the last pending bit clears: div_upd_done pulses for 1 cycle and div_busy drops in the same cycle.
- div_upd while div_busy=1 is ignored.
- rst_cpub mid-update aborts it; div_upd_done is not pulsed.

Per-core idle FSM (states RUN, CNT, GATED, WAKE):
- idle = (standbywfi & wfi_ckg_en) | (standbywfe & wfe_ckg_en).
- wake = !nIRQ | !nFIQ | !idle.
- RUN: core_clk_en=1. If idle, go to CNT and clear idle_cnt.
- CNT: core_clk_en=1.
  - !idle or wake → RUN.
  - Else if idle_cnt==idle_thresh → GATED.
  - Else idle_cnt++.
  - idle_thresh=0 → GATED on the cycle after entering CNT.
- GATED: core_clk_en=0. If wake → WAKE.
  - core_clk_en rises the cycle after wake is sampled (1-cycle wake latency).
- WAKE: core_clk_en=1; unconditionally → RUN next cycle. This guarantees at least 2 ungated cycles before re-gating is possible.
- Reset hold: while ncorereset[c]=0, the FSM is held in RUN with core_clk_en=1, so reset propagates.

Reset sequencing per core:
- core_rst_req=1: ncorereset=0 and the delay counter reloads RST_DLY.
- core_rst_req=0: the counter decrements each cycle.
- ncorereset goes to 1 on the cycle after the counter reaches 0. Total time = RST_DLY cycles of low after the request drops.
- A request re-asserted mid-countdown reloads the counter.
- After rst_cpub drops, every core releases at cycle RST_DLY, since core_rst_req=0.

Decomposition:
- Package cru_cpub_pkg holds:
  - idle-FSM state enum (RUN, CNT, GATED, WAKE).
  - default parameter constants.
  - a function extracting divide field i from div_con.
- One sub-module, cru_core_idle_ctrl, contains the per-core idle FSM plus reset-delay counter; it is instantiated NUM_CORE times in a generate loop.
- Divider channels are inline generate logic.

Test Plan:
1. Reset-release timing: div_con fields={2,1,0}, release reset → clken_div[0] every 3 cycles, [1] every 2, [2] every cycle, all high in cycle 1; ncorereset rises after exactly 16 cycles.
2. Runtime update: ch0 ratio 3→5, div_upd asserted mid-period → exactly one pulse at the old spacing completes, then spacing 6; div_upd_done pulses once; a second div_upd while busy is ignored.
3. Idle gating: wfi_ckg_en[1]=1, idle_thresh=4, standbywfi[1] held → core_clk_en[1] falls 6 cycles after standbywfi rises; other cores remain 1.
4. Wake: core 1 gated, nIRQ[1]=0 for one cycle → core_clk_en[1]=1 next cycle and stays 1 for ≥2 cycles.
5. Abort count: standbywfe[2] with wfe_ckg_en[2]=1, idle_thresh=10, drop standbywfe after 5 cycles → never gated; the FSM returns to RUN.
6. Soft reset: core_rst_req[3] pulsed for 3 cycles, re-pulsed at countdown=5 → ncorereset[3] low until 16 cycles after the second drop; core_clk_en[3]=1 throughout.

Source files
------------

// File: rtl/cru_cpub_pkg.sv
// Shared types and helpers for the CPU subsystem clock-enable / core-reset controller.
package cru_cpub_pkg;

    localparam int DEF_NUM_CORE = 4;
    localparam int DEF_NUM_DIV  = 3;
    localparam int DEF_DIV_W    = 4;
    localparam int DEF_IDLE_W   = 8;
    localparam int DEF_RST_DLY  = 16;
    localparam int FIELD_VEC_W  = 64;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_CNT   = 2'd1,
        ST_GATED = 2'd2,
        ST_WAKE  = 2'd3
    } idle_state_e;

    function automatic logic [FIELD_VEC_W-1:0] div_field(
        input logic [FIELD_VEC_W-1:0] vec,
        input int unsigned            idx,
        input int unsigned            w
    );
        logic [FIELD_VEC_W-1:0] mask;
        mask = (FIELD_VEC_W'(1) << w) - FIELD_VEC_W'(1);
        return (vec >> (idx * w)) & mask;
    endfunction

endpackage

// File: rtl/cru_core_idle_ctrl.sv
// Per-core WFI/WFE idle clock gating FSM and soft-reset release delay.
module cru_core_idle_ctrl
    import cru_cpub_pkg::*;
#(
    parameter int IDLE_W  = DEF_IDLE_W,
    parameter int RST_DLY = DEF_RST_DLY
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              standbywfi_i,
    input  logic              standbywfe_i,
    input  logic              nirq_i,
    input  logic              nfiq_i,
    input  logic              wfi_ckg_en_i,
    input  logic              wfe_ckg_en_i,
    input  logic [IDLE_W-1:0] idle_thresh_i,
    input  logic              rst_req_i,
    output logic              clk_en_o,
    output logic              nreset_o
);

    localparam int DLY_W = $clog2(RST_DLY + 1);
    localparam logic [DLY_W-1:0] DLY_INIT = DLY_W'(RST_DLY);

    idle_state_e       state_q, state_d;
    logic [IDLE_W-1:0] cnt_q, cnt_d;
    logic [DLY_W-1:0]  dly_q, dly_d;
    logic              idle;
    logic              wake;
    logic              nrst;

    assign idle = (standbywfi_i & wfi_ckg_en_i)
                | (standbywfe_i & wfe_ckg_en_i);
    assign wake = !nirq_i || !nfiq_i || !idle;

    always_comb begin
        dly_d = dly_q;
        if (rst_i || rst_req_i) begin
            dly_d = DLY_INIT;
        end else if (dly_q != '0) begin
            dly_d = dly_q - DLY_W'(1);
        end
    end

    assign nrst     = (dly_q == '0) && !rst_i && !rst_req_i;
    assign nreset_o = nrst;

    // Core held in reset must see a running clock so reset can propagate.
    assign clk_en_o = (state_q != ST_GATED) || !nrst;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (idle) begin
                    state_d = ST_CNT;
                    cnt_d   = '0;
                end
            end
            ST_CNT: begin
                if (wake) begin
                    state_d = ST_RUN;
                end else if (cnt_q == idle_thresh_i) begin
                    state_d = ST_GATED;
                end else begin
                    cnt_d = cnt_q + IDLE_W'(1);
                end
            end
            ST_GATED: begin
                if (wake) begin
                    state_d = ST_WAKE;
                end
            end
            ST_WAKE: begin
                state_d = ST_RUN;
            end
        endcase
        if (!nrst) begin
            state_d = ST_RUN;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            dly_q   <= DLY_INIT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dly_q   <= dly_d;
        end
    end

endmodule

// File: rtl/cru_cpub_clken_ctrl.sv
// CPU subsystem divided clock enables with glitch-free ratio update,
// per-core idle clock gating and soft-reset sequencing.
module cru_cpub_clken_ctrl
    import cru_cpub_pkg::*;
#(
    parameter int NUM_CORE = DEF_NUM_CORE,
    parameter int NUM_DIV  = DEF_NUM_DIV,
    parameter int DIV_W    = DEF_DIV_W,
    parameter int IDLE_W   = DEF_IDLE_W,
    parameter int RST_DLY  = DEF_RST_DLY
) (
    input  logic                     clk_cpub,
    input  logic                     rst_cpub,
    input  logic [NUM_DIV*DIV_W-1:0] div_con,
    input  logic                     div_upd,
    output logic                     div_busy,
    output logic                     div_upd_done,
    output logic [NUM_DIV-1:0]       clken_div,
    input  logic [NUM_CORE-1:0]      standbywfi,
    input  logic [NUM_CORE-1:0]      standbywfe,
    input  logic [NUM_CORE-1:0]      nIRQ,
    input  logic [NUM_CORE-1:0]      nFIQ,
    input  logic [NUM_CORE-1:0]      wfi_ckg_en,
    input  logic [NUM_CORE-1:0]      wfe_ckg_en,
    input  logic [IDLE_W-1:0]        idle_thresh,
    input  logic [NUM_CORE-1:0]      core_rst_req,
    output logic [NUM_CORE-1:0]      core_clk_en,
    output logic [NUM_CORE-1:0]      ncorereset
);

    logic [NUM_DIV*DIV_W-1:0] shadow_q, shadow_d;
    logic [NUM_DIV-1:0]       pend_q, pend_d;
    logic [NUM_DIV-1:0]       wrap;
    logic                     done_q, done_d;
    logic                     upd_take;

    assign upd_take = div_upd && (pend_q == '0);

    always_comb begin
        pend_d   = pend_q & ~wrap;
        shadow_d = shadow_q;
        if (upd_take) begin
            pend_d   = '1;
            shadow_d = div_con;
        end
        done_d = (pend_q != '0) && (pend_d == '0);
    end

    always_ff @(posedge clk_cpub) begin
        if (rst_cpub) begin
            pend_q   <= '0;
            shadow_q <= '0;
            done_q   <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            shadow_q <= shadow_d;
            done_q   <= done_d;
        end
    end

    assign div_busy     = (pend_q != '0) && !rst_cpub;
    assign div_upd_done = done_q && !rst_cpub;

    for (genvar i = 0; i < NUM_DIV; i++) begin : g_div
        logic [DIV_W-1:0] cnt_q, cnt_d;
        logic [DIV_W-1:0] act_q, act_d;
        logic [DIV_W-1:0] req_val;
        logic [DIV_W-1:0] new_val;

        assign req_val = DIV_W'(div_field(FIELD_VEC_W'(div_con), i, DIV_W));
        assign new_val = DIV_W'(div_field(FIELD_VEC_W'(shadow_q), i, DIV_W));

        assign wrap[i]      = (cnt_q == act_q);
        assign clken_div[i] = (cnt_q == '0) && !rst_cpub;

        // New ratio takes effect only at a wrap, so the pulse at 0 is kept.
        always_comb begin
            cnt_d = wrap[i] ? '0 : cnt_q + DIV_W'(1);
            act_d = act_q;
            if (wrap[i] && pend_q[i]) begin
                act_d = new_val;
            end
        end

        always_ff @(posedge clk_cpub) begin
            if (rst_cpub) begin
                cnt_q <= '0;
                act_q <= req_val;
            end else begin
                cnt_q <= cnt_d;
                act_q <= act_d;
            end
        end
    end

    for (genvar c = 0; c < NUM_CORE; c++) begin : g_core
        cru_core_idle_ctrl #(
            .IDLE_W  (IDLE_W),
            .RST_DLY (RST_DLY)
        ) u_core (
            .clk_i         (clk_cpub),
            .rst_i         (rst_cpub),
            .standbywfi_i  (standbywfi[c]),
            .standbywfe_i  (standbywfe[c]),
            .nirq_i        (nIRQ[c]),
            .nfiq_i        (nFIQ[c]),
            .wfi_ckg_en_i  (wfi_ckg_en[c]),
            .wfe_ckg_en_i  (wfe_ckg_en[c]),
            .idle_thresh_i (idle_thresh),
            .rst_req_i     (core_rst_req[c]),
            .clk_en_o      (core_clk_en[c]),
            .nreset_o      (ncorereset[c])
        );
    end

endmodule

// File: tb/tb_cru_cpub_clken_ctrl.sv
// Directed bench for cru_cpub_clken_ctrl: divider timing/update, idle gating, soft reset.
module tb_cru_cpub_clken_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] div_con;
    logic        div_upd;
    logic        div_busy;
    logic        div_upd_done;
    logic [2:0]  clken_div;
    logic [3:0]  standbywfi;
    logic [3:0]  standbywfe;
    logic [3:0]  nIRQ;
    logic [3:0]  nFIQ;
    logic [3:0]  wfi_ckg_en;
    logic [3:0]  wfe_ckg_en;
    logic [7:0]  idle_thresh;
    logic [3:0]  core_rst_req;
    logic [3:0]  core_clk_en;
    logic [3:0]  ncorereset;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic        upd;
        logic [11:0] dcon;
        logic [2:0]  e_clk;
        logic [3:0]  e_cke;
        logic [3:0]  e_nrst;
        logic        e_busy;
        logic        e_done;
    } vec_t;

    vec_t tbl[9];

    cru_cpub_clken_ctrl dut (
        .clk_cpub     (clk),
        .rst_cpub     (rst),
        .div_con      (div_con),
        .div_upd      (div_upd),
        .div_busy     (div_busy),
        .div_upd_done (div_upd_done),
        .clken_div    (clken_div),
        .standbywfi   (standbywfi),
        .standbywfe   (standbywfe),
        .nIRQ         (nIRQ),
        .nFIQ         (nFIQ),
        .wfi_ckg_en   (wfi_ckg_en),
        .wfe_ckg_en   (wfe_ckg_en),
        .idle_thresh  (idle_thresh),
        .core_rst_req (core_rst_req),
        .core_clk_en  (core_clk_en),
        .ncorereset   (ncorereset)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input int cyc,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
        end
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 12'h012, 3'b000, 4'hF, 4'h0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 12'h012, 3'b000, 4'hF, 4'h0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 12'h012, 3'b111, 4'hF, 4'h0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 12'h012, 3'b100, 4'hF, 4'h0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 12'h012, 3'b110, 4'hF, 4'h0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 12'h012, 3'b101, 4'hF, 4'h0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 12'h012, 3'b110, 4'hF, 4'h0, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 12'h012, 3'b100, 4'hF, 4'h0, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 12'h012, 3'b111, 4'hF, 4'h0, 1'b0, 1'b0};

        rst          = 1'b1;
        div_con      = 12'h012;
        div_upd      = 1'b0;
        standbywfi   = '0;
        standbywfe   = '0;
        nIRQ         = '1;
        nFIQ         = '1;
        wfi_ckg_en   = '0;
        wfe_ckg_en   = '0;
        idle_thresh  = '0;
        core_rst_req = '0;
        tick();

        // reset state and release timing
        for (int i = 0; i < 9; i++) begin
            rst     = tbl[i].rst;
            div_upd = tbl[i].upd;
            div_con = tbl[i].dcon;
            #1;
            chk("t1_clken", i, 32'(clken_div), 32'(tbl[i].e_clk));
            chk("t1_cke", i, 32'(core_clk_en), 32'(tbl[i].e_cke));
            chk("t1_nrst", i, 32'(ncorereset), 32'(tbl[i].e_nrst));
            chk("t1_busy", i, 32'(div_busy), 32'(tbl[i].e_busy));
            chk("t1_done", i, 32'(div_upd_done), 32'(tbl[i].e_done));
            tick();
        end
        for (int r = 7; r < 18; r++) begin
            #1;
            chk("t1_nrst_rel", r, 32'(ncorereset), (r >= 16) ? 32'hF : 32'h0);
            tick();
        end

        // runtime ratio update on channel 0: 3 -> 5
        rst     = 1'b1;
        div_con = 12'h013;
        tick();
        tick();
        rst = 1'b0;
        for (int r = 0; r < 22; r++) begin
            div_upd = (r == 5) || (r == 6);
            if (r == 5) div_con = 12'h015;
            else if (r == 6) div_con = 12'h010;
            else div_con = 12'h015;
            #1;
            chk("t2_c0", r, 32'(clken_div[0]),
                32'((r == 0) || (r == 4) || (r == 8) || (r == 14) || (r == 20)));
            chk("t2_c2", r, 32'(clken_div[2]), 32'h1);
            chk("t2_busy", r, 32'(div_busy), 32'((r == 6) || (r == 7)));
            chk("t2_done", r, 32'(div_upd_done), 32'(r == 8));
            tick();
        end

        // reset in the middle of an update aborts it
        div_upd = 1'b1;
        div_con = 12'h013;
        tick();
        div_upd = 1'b0;
        rst     = 1'b1;
        #1;
        chk("abort_busy_rst", 0, 32'(div_busy), 32'h0);
        tick();
        rst = 1'b0;
        for (int a = 0; a < 10; a++) begin
            #1;
            chk("abort_busy", a, 32'(div_busy), 32'h0);
            chk("abort_done", a, 32'(div_upd_done), 32'h0);
            tick();
        end
        for (int a = 10; a < 20; a++) tick();

        // idle gating on core 1 followed by an IRQ wake
        wfi_ckg_en  = 4'b0010;
        idle_thresh = 8'd4;
        for (int s = 0; s < 20; s++) begin
            standbywfi = (s < 16) ? 4'b0010 : 4'b0000;
            nIRQ       = (s == 8) ? 4'b1101 : 4'b1111;
            #1;
            chk("t3_cke", s, 32'(core_clk_en),
                ((s == 6) || (s == 7) || (s == 8) || (s == 16)) ? 32'hD : 32'hF);
            tick();
        end
        wfi_ckg_en = '0;

        // WFE count aborted before threshold, then zero-threshold gating
        wfe_ckg_en  = 4'b0100;
        idle_thresh = 8'd10;
        for (int t = 0; t < 20; t++) begin
            standbywfe = (t < 5) ? 4'b0100 : 4'b0000;
            #1;
            chk("t5_cke", t, 32'(core_clk_en), 32'hF);
            tick();
        end
        idle_thresh = 8'd0;
        for (int u = 0; u < 6; u++) begin
            standbywfe = (u < 4) ? 4'b0100 : 4'b0000;
            #1;
            chk("t5_thr0", u, 32'(core_clk_en),
                ((u >= 2) && (u <= 4)) ? 32'hB : 32'hF);
            tick();
        end
        wfe_ckg_en = '0;

        // soft reset of core 3 with a re-pulse mid-countdown
        for (int k = 0; k < 34; k++) begin
            core_rst_req = ((k < 3) || (k == 14) || (k == 15)) ? 4'b1000 : 4'b0000;
            #1;
            chk("t6_nrst", k, 32'(ncorereset), (k >= 32) ? 32'hF : 32'h7);
            chk("t6_cke", k, 32'(core_clk_en), 32'hF);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
